// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states and
// width-generic helpers for byte enables, store lane replication and load extension.
package lsu_pkg;

    localparam int MAX_XLEN = 64;
    localparam int MAX_BE_W = MAX_XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } lsu_state_e;

    function automatic logic size_legal(input logic [2:0] funct3, input int xlen);
        logic ok;
        ok = (funct3 != 3'b111);
        if (xlen == 32 && (funct3 == F3_D || funct3 == F3_WU)) ok = 1'b0;
        return ok;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [MAX_BE_W-1:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        logic [MAX_BE_W-1:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic [MAX_XLEN-1:0] replicate(input logic [1:0] size, input logic [MAX_XLEN-1:0] d);
        case (size)
            2'd0:    return {8{d[7:0]}};
            2'd1:    return {4{d[15:0]}};
            2'd2:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    // Lane is already shifted down to bit 0; funct3[2] selects zero extension.
    function automatic logic [MAX_XLEN-1:0] extend(input logic [2:0] funct3, input logic [MAX_XLEN-1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = lane[7:0];
        h = lane[15:0];
        w = lane[31:0];
        case (funct3[1:0])
            2'd0:    return funct3[2] ? MAX_XLEN'(lane[7:0])  : MAX_XLEN'(b);
            2'd1:    return funct3[2] ? MAX_XLEN'(lane[15:0]) : MAX_XLEN'(h);
            2'd2:    return funct3[2] ? MAX_XLEN'(lane[31:0]) : MAX_XLEN'(w);
            default: return lane;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replicated write data from the
// incoming access, load lane extraction and sign/zero extension from the latched access.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [2:0]       st_funct3,
    input  logic [OFF_W-1:0] st_off,
    input  logic [XLEN-1:0]  st_data,
    output logic [BE_W-1:0]  st_be,
    output logic [XLEN-1:0]  st_wdata,
    input  logic [2:0]       ld_funct3,
    input  logic [OFF_W-1:0] ld_off,
    input  logic [XLEN-1:0]  ld_rdata,
    output logic [XLEN-1:0]  ld_data
);

    logic [MAX_BE_W-1:0] be_full;
    logic [MAX_XLEN-1:0] wdata_full;
    logic [MAX_XLEN-1:0] lane;
    logic [MAX_XLEN-1:0] ext_full;

    always_comb begin
        be_full    = byte_en(st_funct3[1:0], 3'(st_off));
        wdata_full = replicate(st_funct3[1:0], MAX_XLEN'(st_data));
        lane       = MAX_XLEN'(ld_rdata) >> {3'(ld_off), 3'b000};
        ext_full   = extend(ld_funct3, lane);
    end

    assign st_be    = be_full[BE_W-1:0];
    assign st_wdata = wdata_full[XLEN-1:0];
    assign ld_data  = ext_full[XLEN-1:0];

    // Upper halves of the 64-bit helpers are meaningless for a 32-bit datapath.
    if (XLEN < MAX_XLEN) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^{be_full[MAX_BE_W-1:BE_W], wdata_full[MAX_XLEN-1:XLEN],
                             ext_full[MAX_XLEN-1:XLEN]};
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in the MEM slot: one registered stage for ALU results, req/ack
// memory handshake with stall, misalignment trap and bus timeout.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              wb_en_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              stall_o,
    output logic              wb_en_o,
    output logic [4:0]        rd_addr_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    lsu_state_e state, state_nxt;

    logic             is_mem, legal, aligned;
    logic             accept, fault, ack_busy, timeout;
    logic [CNT_W-1:0] cnt;
    logic [OFF_W-1:0] off_in;

    logic             load_p1;
    logic [2:0]       funct3_p1;
    logic [OFF_W-1:0] off_p1;
    logic [4:0]       rd_p1;

    logic [BE_W-1:0]  st_be;
    logic [XLEN-1:0]  st_wdata;
    logic [XLEN-1:0]  ld_data;

    assign is_mem  = load_i | store_i;
    assign off_in  = addr_i[OFF_W-1:0];
    assign legal   = size_legal(funct3_i, XLEN);
    assign aligned = (3'(off_in) & align_mask(funct3_i[1:0])) == 3'b000;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fault     = 1'b0;
        ack_busy  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i && is_mem) begin
                    if (legal && aligned) begin
                        accept    = 1'b1;
                        state_nxt = ST_BUSY;
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (mem_ack_i) begin
                    ack_busy  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stall_o = accept | (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3 (funct3_i),
        .st_off    (off_in),
        .st_data   (store_data_i),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_funct3 (funct3_p1),
        .ld_off    (off_p1),
        .ld_rdata  (mem_rdata_i),
        .ld_data   (ld_data)
    );

    // Request stage: memory-side registers held stable for the whole BUSY period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            load_p1     <= 1'b0;
            cnt         <= '0;
        end else if (accept) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= store_i;
            mem_be_o    <= st_be;
            mem_addr_o  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_o <= st_wdata;
            load_p1     <= ~store_i;
            cnt         <= '0;
        end else if (ack_busy || timeout) begin
            mem_req_o <= 1'b0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_p1 <= funct3_i;
            off_p1    <= off_in;
            rd_p1     <= rd_addr_i;
        end
    end

    // Write-back stage: everything WB sees is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_o    <= 1'b0;
            rd_addr_o  <= '0;
            wb_data_o  <= '0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            wb_en_o    <= 1'b0;
            misalign_o <= fault;
            bus_err_o  <= timeout;
            if (state == ST_IDLE && valid_i && !is_mem) begin
                wb_en_o   <= wb_en_i;
                rd_addr_o <= rd_addr_i;
                wb_data_o <= wb_data_i;
            end else if (ack_busy) begin
                wb_en_o   <= load_p1;
                rd_addr_o <= rd_p1;
                if (load_p1) wb_data_o <= ld_data;
            end
        end
    end

endmodule
